// File: rtl/arbitro_memoria.sv
// arbitro_memoria: round-robin two-port arbiter and access sequencer for the byte-lane data memory
module arbitro_memoria #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [1:0]            tipo0,
    input  logic [1:0]            tipo1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ocupado,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_EscMen,
    output logic                  mem_ReadMen,
    output logic [1:0]            mem_DataType,
    input  logic [DATA_WIDTH-1:0] mem_saida
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;
    localparam logic [1:0] LAT = 2'(MEM_LAT);
    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [1:0]            tipo_q, tipo_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        tipo_d  = tipo_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: if (req0 || req1) begin
                // on a tie the requester not served last wins
                gnt_d   = (req0 && req1) ? ~last_q : req1;
                last_d  = gnt_d;
                we_d    = gnt_d ? we1 : we0;
                tipo_d  = gnt_d ? tipo1 : tipo0;
                addr_d  = gnt_d ? addr1 : addr0;
                wdata_d = gnt_d ? wdata1 : wdata0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_d   = LAT;
                state_d = we_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    rdata_d = mem_saida;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            tipo_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            tipo_q  <= tipo_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    assign ocupado      = state_q != ST_IDLE;
    assign ack0         = state_q == ST_RESP && !gnt_q;
    assign ack1         = state_q == ST_RESP && gnt_q;
    assign mem_EscMen   = state_q == ST_ACCESS && we_q;
    assign mem_ReadMen  = (state_q == ST_ACCESS && !we_q) || state_q == ST_WAIT;
    assign mem_addr     = addr_q;
    assign mem_data     = wdata_q;
    assign mem_DataType = tipo_q;
    assign rdata        = rdata_q;
endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: directed and random transactions checked against a transaction-level memory model
module tb_arbitro_memoria;
    localparam int LAT = 3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq [2];
    logic        wq [2];
    logic [1:0]  tq [2];
    logic [7:0]  aq [2];
    logic [31:0] dq [2];
    logic        ack0, ack1, ocupado, mem_EscMen, mem_ReadMen;
    logic [1:0]  mem_DataType;
    logic [7:0]  mem_addr;
    logic [31:0] rdata, mem_data, mem_saida;
    logic [7:0]  phys [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    int          n_chk = 0;
    int          n_err = 0;
    int          last_g = 1;
    logic [31:0] last_rd = '0;
    logic [7:0]  last_a = '0;

    arbitro_memoria #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LAT(LAT)) dut (
        .clock(clk), .reset(rst_n),
        .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
        .tipo0(tq[0]), .tipo1(tq[1]), .addr0(aq[0]), .addr1(aq[1]),
        .wdata0(dq[0]), .wdata1(dq[1]),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .ocupado(ocupado),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_EscMen(mem_EscMen),
        .mem_ReadMen(mem_ReadMen), .mem_DataType(mem_DataType), .mem_saida(mem_saida)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] t);
        return t == 2'b01 ? 1 : t == 2'b10 ? 2 : 4;
    endfunction

    // little-endian byte-lane memory seen by the DUT
    always @(posedge clk)
        if (mem_EscMen)
            for (int i = 0; i < nbytes(mem_DataType); i++)
                phys[(int'(mem_addr) + i) % 256] <= mem_data[8*i +: 8];

    always_comb begin
        mem_saida = '0;
        for (int i = 0; i < nbytes(mem_DataType); i++)
            mem_saida = mem_saida | (32'(phys[(int'(mem_addr) + i) % 256]) << (8 * i));
    end

    function automatic logic [31:0] ref_read(input logic [7:0] a, input logic [1:0] t);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes(t); i++) v = v | (32'(ref_mem[(int'(a) + i) % 256]) << (8 * i));
        return v;
    endfunction

    task automatic ref_write(input logic [7:0] a, input logic [1:0] t, input logic [31:0] d);
        for (int i = 0; i < nbytes(t); i++) ref_mem[(int'(a) + i) % 256] = d[8*i +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int r, input logic w, input logic [1:0] t, input logic [7:0] a, input logic [31:0] d);
        wq[r] = w;
        tq[r] = t;
        aq[r] = a;
        dq[r] = d;
        rq[r] = 1'b1;
    endtask

    task automatic rand_fields(input int r);
        issue(r, 1'($urandom), 2'($urandom), 8'($urandom), $urandom);
    endtask

    // follows one transaction of requester r from grant to ack; returns in the ack cycle
    task automatic run_txn(input int r, input bit after_ack, input bit perturb);
        int k, esc;
        bit saw;
        logic w;
        logic [1:0] t;
        logic [7:0] a;
        logic [31:0] d;
        w = wq[r];
        t = tq[r];
        a = aq[r];
        d = dq[r];
        if (after_ack) begin
            @(negedge clk);
            chk("idle_flags", 32'({ocupado, mem_EscMen, mem_ReadMen, ack0, ack1}), 32'd0);
            chk("idle_addr_hold", 32'(mem_addr), 32'(last_a));
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ocupado && k < 10);
        chk("grant_delay", 32'(k), 32'd1);
        chk("acc_addr", 32'(mem_addr), 32'(a));
        chk("acc_size", 32'(mem_DataType), 32'(t));
        chk("acc_en", 32'({mem_EscMen, mem_ReadMen}), 32'({w, !w}));
        if (w) chk("acc_wdata", mem_data, d);
        if (perturb) begin
            aq[r] = ~a;
            dq[r] = ~d;
        end
        esc = int'(mem_EscMen);
        saw = 1'b0;
        while (!saw && k < 12) begin
            @(negedge clk);
            k++;
            chk("one_ack", 32'(ack0 & ack1), 32'd0);
            if (ack0 || ack1) saw = 1'b1;
            else begin
                esc += int'(mem_EscMen);
                chk("wait_rden", 32'(mem_ReadMen), 32'(!w));
                chk("wait_addr", 32'(mem_addr), 32'(a));
            end
        end
        chk("ack_seen", 32'(saw), 32'd1);
        chk("ack_who", 32'({ack1, ack0}), 32'(r ? 2 : 1));
        chk("latency", 32'(k), 32'(w ? 2 : 2 + LAT));
        chk("write_pulses", 32'(esc), 32'(w));
        chk("resp_en", 32'({mem_EscMen, mem_ReadMen}), 32'd0);
        chk("resp_addr", 32'(mem_addr), 32'(a));
        if (w) begin
            ref_write(a, t, d);
            chk("rdata_hold", rdata, last_rd);
        end else begin
            last_rd = ref_read(a, t);
            chk("rdata", rdata, last_rd);
        end
        last_g = r;
        last_a = a;
    endtask

    initial begin
        int nxt;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        issue(0, 1'b1, 2'b00, 8'h20, 32'h11112222);
        issue(1, 1'b1, 2'b00, 8'h24, 32'h33334444);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_flags", 32'({ack0, ack1, ocupado, mem_EscMen, mem_ReadMen, mem_DataType}), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_addr_data", mem_data | 32'(mem_addr), 32'd0);
        end
        rst_n = 1'b1;
        run_txn(0, 1'b0, 1'b0);
        rq[0] = 1'b0;
        run_txn(1, 1'b1, 1'b0);
        rq[1] = 1'b0;

        issue(0, 1'b1, 2'b00, 8'h10, 32'hDEADBEEF);
        run_txn(0, 1'b1, 1'b0);
        issue(0, 1'b0, 2'b00, 8'h10, 32'h0);
        run_txn(0, 1'b1, 1'b0);
        chk("word_rb", rdata, 32'hDEADBEEF);
        rq[0] = 1'b0;

        issue(1, 1'b1, 2'b01, 8'h13, 32'h000000A5);
        run_txn(1, 1'b1, 1'b0);
        issue(1, 1'b0, 2'b01, 8'h13, 32'h0);
        run_txn(1, 1'b1, 1'b0);
        chk("byte_rb", rdata, 32'h000000A5);
        rq[1] = 1'b0;
        issue(0, 1'b1, 2'b10, 8'h06, 32'h00001234);
        run_txn(0, 1'b1, 1'b0);
        issue(0, 1'b0, 2'b10, 8'h06, 32'h0);
        run_txn(0, 1'b1, 1'b0);
        chk("half_rb", rdata, 32'h00001234);
        rq[0] = 1'b0;

        issue(1, 1'b1, 2'b00, 8'h40, 32'hCAFEF00D);
        run_txn(1, 1'b1, 1'b1);
        issue(1, 1'b0, 2'b00, 8'h40, 32'h0);
        run_txn(1, 1'b1, 1'b0);
        chk("latched_rb", rdata, 32'hCAFEF00D);
        rq[1] = 1'b0;

        rand_fields(0);
        rand_fields(1);
        nxt = 1 - last_g;
        chk("rr_first", 32'(nxt), 32'd0);
        for (int n = 0; n < 6; n++) begin
            run_txn(nxt, 1'b1, 1'b0);
            rand_fields(nxt);
            nxt = 1 - nxt;
        end

        for (int n = 0; n < 40; n++) begin
            int j;
            rq[last_g] = 1'b0;
            for (int i = 0; i < 2; i++)
                if (!rq[i] && $urandom_range(0, 1) == 1) rand_fields(i);
            if (!rq[0] && !rq[1]) begin
                j = int'($urandom_range(0, 1));
                rand_fields(j);
            end
            nxt = (rq[0] && rq[1]) ? 1 - last_g : (rq[1] ? 1 : 0);
            run_txn(nxt, 1'b1, 1'b0);
        end

        rq[0] = 1'b0;
        rq[1] = 1'b0;
        issue(0, 1'b0, 2'b00, 8'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(ocupado), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wait", 32'(mem_ReadMen), 32'd1);
        rst_n = 1'b0;
        rq[0] = 1'b0;
        #1;
        chk("abort_flags", 32'({ocupado, mem_ReadMen, mem_EscMen, ack0, ack1}), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        last_rd = '0;
        last_g = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_noack", 32'({ack0, ack1, ocupado}), 32'd0);
        end
        rst_n = 1'b1;
        issue(0, 1'b0, 2'b00, 8'h10, 32'h0);
        run_txn(0, 1'b0, 1'b0);
        rq[0] = 1'b0;
        @(negedge clk);
        chk("final_idle", 32'({ocupado, ack0, ack1}), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
